lru_victim_tracker: RTL and testbench

- Parametrised per-set replacement-state tracker for the N-way set-associative cache in the memory stage.
- Keeps a valid bit and a true-LRU age per way for every set.
- Updates state on hits/fills and invalidations.
- On request, returns a registered victim: the lowest-indexed invalid way if one exists, otherwise the oldest valid way.
- Generalises the fixed 4-way lowest-set-bit encoder to any power-of-two way count, with sequential age tracking.

---
 rtl/lru_pkg.sv | 24 ++
 rtl/prio_enc_lsb.sv | 24 ++
 rtl/lru_victim_tracker.sv | 117 +++++++++++
 tb/tb_lru_victim_tracker.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/lru_pkg.sv
// Shared types and constants for the LRU victim tracker.
// Default geometry typedefs plus a constant-function log2 for older toolflows.
package lru_pkg;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned LRU_NUM_SETS = 16;
  localparam int unsigned LRU_NUM_WAYS = 4;
  localparam int unsigned LRU_SET_W    = clog2_f(LRU_NUM_SETS);
  localparam int unsigned LRU_WAY_W    = clog2_f(LRU_NUM_WAYS);

  typedef logic [LRU_SET_W-1:0] set_idx_t;
  typedef logic [LRU_WAY_W-1:0] way_idx_t;

  localparam int unsigned AGE_MRU = 0;

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-set-bit priority encoder with an any-set flag.
module prio_enc_lsb
  import lru_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any_set
);

  localparam int unsigned IDX_W = $clog2(N);

  always_comb begin
    idx = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign any_set = |req;

endmodule

// File: rtl/lru_victim_tracker.sv
// Per-set valid bits and true-LRU ages; returns a registered victim way one
// cycle after a request, preferring the lowest invalid way over the LRU way.
module lru_victim_tracker
  import lru_pkg::*;
#(
  parameter int unsigned NUM_SETS = 16,
  parameter int unsigned NUM_WAYS = 4,
  localparam int unsigned SET_W   = $clog2(NUM_SETS),
  localparam int unsigned WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             touch_valid,
  input  logic [SET_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             inval_valid,
  input  logic [SET_W-1:0] inval_set,
  input  logic [WAY_W-1:0] inval_way,
  input  logic             req_valid,
  input  logic [SET_W-1:0] req_set,
  output logic             victim_valid,
  output logic [WAY_W-1:0] victim_way,
  output logic             victim_free
);

  localparam logic [WAY_W-1:0] AgeLru = WAY_W'(NUM_WAYS - 1);
  localparam logic [WAY_W-1:0] AgeMru = WAY_W'(AGE_MRU);

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]    age_d   [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]    touch_age;

  logic                victim_valid_q;
  logic [WAY_W-1:0]    victim_way_q;
  logic                victim_free_q;

  logic [NUM_WAYS-1:0] free_vec;
  logic [NUM_WAYS-1:0] lru_vec;
  logic [WAY_W-1:0]    free_idx;
  logic [WAY_W-1:0]    lru_idx;
  logic                free_any;
  logic                lru_any;

  // Invalidate is applied first so a same-way touch overrides it.
  always_comb begin
    valid_d   = valid_q;
    age_d     = age_q;
    touch_age = age_q[touch_set][touch_way];
    if (inval_valid) begin
      valid_d[inval_set][inval_way] = 1'b0;
    end
    if (touch_valid) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[touch_set][w] < touch_age) begin
          age_d[touch_set][w] = age_q[touch_set][w] + 1'b1;
        end
      end
      age_d[touch_set][touch_way]   = AgeMru;
      valid_d[touch_set][touch_way] = 1'b1;
    end
  end

  // Lookup reads pre-update state, so same-cycle touches do not disturb it.
  always_comb begin
    free_vec = ~valid_q[req_set];
    lru_vec  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      lru_vec[w] = (age_q[req_set][w] == AgeLru);
    end
  end

  prio_enc_lsb #(
    .N (NUM_WAYS)
  ) u_free_enc (
    .req     (free_vec),
    .idx     (free_idx),
    .any_set (free_any)
  );

  prio_enc_lsb #(
    .N (NUM_WAYS)
  ) u_lru_enc (
    .req     (lru_vec),
    .idx     (lru_idx),
    .any_set (lru_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      victim_free_q  <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      age_q          <= age_d;
      victim_valid_q <= req_valid;
      if (req_valid) begin
        // lru_any is always set while ages stay a permutation.
        victim_way_q  <= free_any ? free_idx : (lru_any ? lru_idx : '0);
        victim_free_q <= free_any;
      end
    end
  end

  assign victim_valid = victim_valid_q;
  assign victim_way   = victim_way_q;
  assign victim_free  = victim_free_q;

endmodule

// File: tb/tb_lru_victim_tracker.sv
// Directed bench for lru_victim_tracker with 4 sets x 4 ways.
module tb_lru_victim_tracker;

  logic       clk;
  logic       reset;
  logic       touch_valid;
  logic [1:0] touch_set;
  logic [1:0] touch_way;
  logic       inval_valid;
  logic [1:0] inval_set;
  logic [1:0] inval_way;
  logic       req_valid;
  logic [1:0] req_set;
  logic       victim_valid;
  logic [1:0] victim_way;
  logic       victim_free;

  int total;
  int bad;

  lru_victim_tracker #(
    .NUM_SETS (4),
    .NUM_WAYS (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .touch_valid  (touch_valid),
    .touch_set    (touch_set),
    .touch_way    (touch_way),
    .inval_valid  (inval_valid),
    .inval_set    (inval_set),
    .inval_way    (inval_way),
    .req_valid    (req_valid),
    .req_set      (req_set),
    .victim_valid (victim_valid),
    .victim_way   (victim_way),
    .victim_free  (victim_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    touch_valid = 1'b0;
    inval_valid = 1'b0;
    req_valid   = 1'b0;
  endtask

  task automatic do_touch(input logic [1:0] s, input logic [1:0] w);
    touch_valid = 1'b1;
    touch_set   = s;
    touch_way   = w;
    step();
    clear_inputs();
  endtask

  task automatic do_inval(input logic [1:0] s, input logic [1:0] w);
    inval_valid = 1'b1;
    inval_set   = s;
    inval_way   = w;
    step();
    clear_inputs();
  endtask

  task automatic do_req(input string tag, input logic [1:0] s,
                        input logic [1:0] exp_way, input logic exp_free);
    req_valid = 1'b1;
    req_set   = s;
    step();
    clear_inputs();
    check_eq({tag, ".vv"}, 32'(victim_valid), 32'd1);
    check_eq({tag, ".way"}, 32'(victim_way), 32'(exp_way));
    check_eq({tag, ".free"}, 32'(victim_free), 32'(exp_free));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_inputs();
    touch_set = '0; touch_way = '0;
    inval_set = '0; inval_way = '0;
    req_set   = '0;
    reset     = 1'b1;
    #2;
    step();
    step();
    reset = 1'b0;
    check_eq("rst.vv", 32'(victim_valid), 32'd0);
    check_eq("rst.way", 32'(victim_way), 32'd0);
    check_eq("rst.free", 32'(victim_free), 32'd0);

    // 1: empty set picks way 0 as free
    do_req("t1", 2'd2, 2'd0, 1'b1);
    step();
    check_eq("t1.idle_vv", 32'(victim_valid), 32'd0);
    check_eq("t1.hold_free", 32'(victim_free), 32'd1);

    // 2: fill set 1 in order -> ages w0=3 w1=2 w2=1 w3=0
    for (int w = 0; w < 4; w++) do_touch(2'd1, 2'(w));
    do_req("t2", 2'd1, 2'd0, 1'b0);

    // 3: touch w0 -> w0=0 w1=3 w2=2 w3=1; re-touching MRU w0 changes nothing
    do_touch(2'd1, 2'd0);
    do_req("t3a", 2'd1, 2'd1, 1'b0);
    do_touch(2'd1, 2'd0);
    do_req("t3b", 2'd1, 2'd1, 1'b0);

    // 4: invalidate way 2, then same-cycle touch+inval of way 2 (touch wins)
    do_inval(2'd1, 2'd2);
    do_req("t4a", 2'd1, 2'd2, 1'b1);
    touch_valid = 1'b1; touch_set = 2'd1; touch_way = 2'd2;
    inval_valid = 1'b1; inval_set = 2'd1; inval_way = 2'd2;
    step();
    clear_inputs();
    // ages now w0=1 w1=3 w2=0 w3=2
    do_req("t4b", 2'd1, 2'd1, 1'b0);
    // touch w1 -> w0=2 w1=0 w2=1 w3=3
    do_touch(2'd1, 2'd1);
    do_req("t4c", 2'd1, 2'd3, 1'b0);

    // 5: make w0 LRU (w0=3 w1=1 w2=2 w3=0), then request with a same-set touch
    do_touch(2'd1, 2'd3);
    req_valid = 1'b1; req_set = 2'd1;
    touch_valid = 1'b1; touch_set = 2'd1; touch_way = 2'd0;
    step();
    clear_inputs();
    check_eq("t5a.vv", 32'(victim_valid), 32'd1);
    check_eq("t5a.way", 32'(victim_way), 32'd0);
    check_eq("t5a.free", 32'(victim_free), 32'd0);
    // ages now w0=0 w1=2 w2=3 w3=1
    do_req("t5b", 2'd1, 2'd2, 1'b0);
    step();
    check_eq("t5.hold_way", 32'(victim_way), 32'd2);

    // independent touch and inval in the same cycle on different ways
    for (int w = 0; w < 4; w++) do_touch(2'd0, 2'(w));
    touch_valid = 1'b1; touch_set = 2'd0; touch_way = 2'd0;
    inval_valid = 1'b1; inval_set = 2'd0; inval_way = 2'd2;
    step();
    clear_inputs();
    do_req("mix", 2'd0, 2'd2, 1'b1);

    // 6: fill set 3, then reset together with a request
    for (int w = 0; w < 4; w++) do_touch(2'd3, 2'(w));
    do_req("t6a", 2'd3, 2'd0, 1'b0);
    reset = 1'b1; req_valid = 1'b1; req_set = 2'd3;
    touch_valid = 1'b1; touch_set = 2'd3; touch_way = 2'd1;
    step();
    reset = 1'b0;
    clear_inputs();
    check_eq("t6.rst_vv", 32'(victim_valid), 32'd0);
    check_eq("t6.rst_way", 32'(victim_way), 32'd0);
    step();
    check_eq("t6.post_vv", 32'(victim_valid), 32'd0);
    do_req("t6b", 2'd3, 2'd0, 1'b1);
    do_req("t6c", 2'd1, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
